// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants for the RV64 fetch front end
package core_pkg;
  localparam int XLEN = 64;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;
  localparam int IMEM_AW_DEFAULT = 14;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, holding {pc, inst} fetch entries
module fetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read once count says they are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction fetch front end; FETCH_BYPASS_EN enables response bypass
module fetch_queue
  import core_pkg::*;
#(
  parameter int              XLEN_P   = XLEN,
  parameter int              IMEM_AW  = IMEM_AW_DEFAULT,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN_P-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [INST_W-1:0]   imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN_P-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic [XLEN_P-1:0]   out_pc,
  output logic [XLEN_P-1:0]   debug_pc
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN_P-1:0]        fetch_pc;
  logic [XLEN_P-1:0]        rsp_pc;
  logic [XLEN_P-1:0]        last_pc;
  logic [INST_W-1:0]        last_inst;
  logic                     rsp_pending;
  logic [CW-1:0]            count;
  logic [CW:0]              inflight;
  logic [XLEN_P+INST_W-1:0] head;
  logic                     bypass;
  logic                     fifo_valid;
  logic                     push;
  logic                     pop;

  // Words queued plus the one still in the BRAM must fit, so a push never meets a full FIFO.
  assign inflight  = {1'b0, count} + {{CW{1'b0}}, rsp_pending};
  assign imem_en   = !reset && !redirect_valid && (inflight < (CW+1)'(FQ_DEPTH));
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign debug_pc  = fetch_pc;

`ifdef FETCH_BYPASS_EN
  assign bypass = (count == '0) && rsp_pending && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_valid = (count != '0) && !redirect_valid;
  assign out_valid  = fifo_valid || bypass;
  assign pop        = fifo_valid && out_ready;
  assign push       = rsp_pending && !redirect_valid && !(bypass && out_ready);

  always_comb begin
    out_inst = last_inst;
    out_pc   = last_pc;
    if (bypass) begin
      out_inst = imem_rdata;
      out_pc   = rsp_pc;
    end else if (count != '0) begin
      out_inst = head[INST_W-1:0];
      out_pc   = head[XLEN_P+INST_W-1:INST_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= '0;
      rsp_pending <= 1'b0;
      last_inst   <= '0;
      last_pc     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc & ~XLEN_P'(3);
      rsp_pending <= 1'b0;
    end else begin
      rsp_pending <= imem_en;
      if (imem_en) begin
        rsp_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN_P'(4);
      end
      // Keep the last delivered word visible while the queue is empty.
      if (out_valid && out_ready) begin
        last_inst <= out_inst;
        last_pc   <= out_pc;
      end
    end
  end

  fetch_fifo #(
    .W     (XLEN_P + INST_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({rsp_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (count)
  );
endmodule
